// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the rv32i instruction fetch stage.
// FETCH_FAULT_EN adds the S_FAULT state used by the fetch-error path.
package fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam int PC_W = 30;

  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID
`ifdef FETCH_FAULT_EN
    ,
    S_FAULT
`endif
  } fetch_state_t;

  // Word-address successor; a redirect from the branch controller wins.
  function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] pc,
                                               input logic            jmp_enable,
                                               input logic [PC_W-1:0] jmp_addr);
    return jmp_enable ? jmp_addr : pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, next-PC mux and request/grant/response FSM.
// Optional FETCH_FAULT_EN adds imem_err/fetch_fault and a sticky fault state.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
`ifdef FETCH_FAULT_EN
  input  logic            imem_err,
  output logic            fetch_fault,
`endif
  output logic [PC_W-1:0] pc,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  input  logic            instr_ack,
  input  logic            jmp_enable,
  input  logic [PC_W-1:0] jmp_addr
);

  fetch_state_t    state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] instr_reg, instr_next;
`ifdef FETCH_FAULT_EN
  logic            fault_reg, fault_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      pc_reg    <= RESET_PC;
      instr_reg <= '0;
`ifdef FETCH_FAULT_EN
      fault_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
`ifdef FETCH_FAULT_EN
      fault_reg <= fault_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
`ifdef FETCH_FAULT_EN
    fault_next = fault_reg;
`endif
    case (state_reg)
      S_IDLE: state_next = S_REQ;
      S_REQ: begin
        if (imem_gnt) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
`ifdef FETCH_FAULT_EN
          if (imem_err) begin
            fault_next = 1'b1;
            state_next = S_FAULT;
          end else begin
            instr_next = imem_rdata;
            state_next = S_VALID;
          end
`else
          instr_next = imem_rdata;
          state_next = S_VALID;
`endif
        end
      end
      // Branch inputs are only meaningful in the retire cycle.
      S_VALID: begin
        if (instr_ack) begin
          pc_next    = next_pc(pc_reg, jmp_enable, jmp_addr);
          state_next = S_REQ;
        end
      end
`ifdef FETCH_FAULT_EN
      S_FAULT: state_next = S_FAULT;
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decode from registered state only.
  assign imem_req    = (state_reg == S_REQ);
  assign instr_valid = (state_reg == S_VALID);
  assign imem_addr   = pc_reg;
  assign pc          = pc_reg;
  assign instr       = instr_reg;
`ifdef FETCH_FAULT_EN
  assign fetch_fault = fault_reg;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed and randomized fetches against an
// expected-PC model; memory handshake timing is driven from the bench itself.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [29:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ack = 1'b0;
  logic        jmp_enable = 1'b0;
  logic [29:0] jmp_addr = '0;
`ifdef FETCH_FAULT_EN
  logic        imem_err = 1'b0;
  logic        fetch_fault;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs = 0;
  int last_req_cyc = -100;
  bit prev_fast = 1'b0;
  logic [29:0] exp_pc;
  logic [31:0] last_data;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
`ifdef FETCH_FAULT_EN
    .imem_err    (imem_err),
    .fetch_fault (fetch_fault),
`endif
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ack   (instr_ack),
    .jmp_enable  (jmp_enable),
    .jmp_addr    (jmp_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (imem_req && imem_gnt) hs <= hs + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", 64'(imem_req), 64'd1);
  endtask

  // One complete fetch: gd grant-delay, rd response-delay, ad ack-delay cycles.
  task automatic fetch_one(input int gd, input int rd, input int ad, input logic je,
                           input logic [29:0] ja, input logic [31:0] data);
    int hs0;
    wait_req();
    hs0 = hs;
    if (prev_fast && gd == 0 && rd == 0 && ad == 0)
      check("throughput", 64'(cyc - last_req_cyc), 64'd3);
    last_req_cyc = cyc;
    check("req_addr", 64'(imem_addr), 64'(exp_pc));
    for (int i = 0; i < gd; i++) begin
      imem_rvalid = 1'($urandom_range(0, 1));
      imem_rdata  = $urandom;
      instr_ack   = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("req_hold", 64'(imem_req), 64'd1);
      check("req_hold_addr", 64'(imem_addr), 64'(exp_pc));
    end
    imem_rvalid = 1'b0;
    instr_ack   = 1'b0;
    imem_gnt    = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    check("wait_req_low", 64'(imem_req), 64'd0);
    for (int i = 0; i < rd; i++) begin
      instr_ack  = 1'($urandom_range(0, 1));
      jmp_enable = 1'($urandom_range(0, 1));
      jmp_addr   = 30'($urandom);
      @(negedge clk);
      check("wait_no_valid", 64'(instr_valid), 64'd0);
      check("wait_pc", 64'(pc), 64'(exp_pc));
    end
    instr_ack   = 1'b0;
    jmp_enable  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    last_data   = data;
    check("valid", 64'(instr_valid), 64'd1);
    check("instr", 64'(instr), 64'(data));
    check("pc", 64'(pc), 64'(exp_pc));
    for (int i = 0; i < ad; i++) begin
      jmp_enable  = 1'($urandom_range(0, 1));
      jmp_addr    = 30'($urandom);
      imem_rvalid = 1'($urandom_range(0, 1));
      imem_rdata  = $urandom;
      @(negedge clk);
      check("stall_valid", 64'(instr_valid), 64'd1);
      check("stall_instr", 64'(instr), 64'(data));
      check("stall_pc", 64'(pc), 64'(exp_pc));
      check("stall_no_req", 64'(imem_req), 64'd0);
    end
    imem_rvalid = 1'b0;
    instr_ack   = 1'b1;
    jmp_enable  = je;
    jmp_addr    = ja;
    @(negedge clk);
    instr_ack  = 1'b0;
    jmp_enable = 1'b0;
    jmp_addr   = 30'($urandom);
    exp_pc = je ? ja : exp_pc + 30'd1;
    check("one_handshake", 64'(hs - hs0), 64'd1);
    check("ack_clears_valid", 64'(instr_valid), 64'd0);
    prev_fast = (gd == 0 && rd == 0 && ad == 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and first fetch
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_pc", 64'(pc), 64'd0);
    check("rst_instr", 64'(instr), 64'd0);
`ifdef FETCH_FAULT_EN
    check("rst_fault", 64'(fetch_fault), 64'd0);
`endif
    rst = 1'b0;
    #1;
    check("idle_no_req", 64'(imem_req), 64'd0);
    @(negedge clk);
    check("first_req", 64'(imem_req), 64'd1);
    check("first_addr", 64'(imem_addr), 64'd0);
    exp_pc = 30'd0;
    fetch_one(0, 0, 0, 1'b0, 30'd0, 32'h0050_0093);

    // Sequential fetches 1..4, then redirect at pc=5 with a stall
    for (int i = 1; i < 5; i++) fetch_one(0, 0, 0, 1'b0, 30'd0, $urandom);
    fetch_one(0, 0, 3, 1'b1, 30'h40, $urandom);
    check("redirect_addr", 64'(imem_addr), 64'h40);

    // Backpressure on every phase
    fetch_one(4, 3, 5, 1'b0, 30'd0, $urandom);

    // Wrap at the top of the word-address space
    fetch_one(0, 0, 0, 1'b1, 30'h3FFF_FFFF, $urandom);
    fetch_one(1, 1, 1, 1'b0, 30'd0, $urandom);
    check("wrap_addr", 64'(imem_addr), 64'd0);
    fetch_one(0, 0, 0, 1'b0, 30'd0, $urandom);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      fetch_one($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0), 30'($urandom), $urandom);
    end

    // Reset while waiting for a response; a late rvalid must be ignored
    wait_req();
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_pc", 64'(pc), 64'd0);
    check("midrst_valid", 64'(instr_valid), 64'd0);
    check("midrst_req", 64'(imem_req), 64'd0);
    rst = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("midrst_req_again", 64'(imem_req), 64'd1);
    check("midrst_instr", 64'(instr), 64'd0);
    check("midrst_novalid", 64'(instr_valid), 64'd0);
    exp_pc = 30'd0;
    prev_fast = 1'b0;
    fetch_one(0, 0, 0, 1'b1, 30'd7, $urandom);

`ifdef FETCH_FAULT_EN
    // Fetch error at pc=7 latches a sticky fault
    wait_req();
    check("fault_addr", 64'(imem_addr), 64'd7);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_err    = 1'b1;
    imem_rdata  = 32'h1234_5678;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_err    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check("fault_sticky", 64'(fetch_fault), 64'd1);
      check("fault_no_req", 64'(imem_req), 64'd0);
      check("fault_no_valid", 64'(instr_valid), 64'd0);
      check("fault_instr_kept", 64'(instr), 64'(last_data));
      imem_rvalid = 1'($urandom_range(0, 1));
      instr_ack   = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    imem_rvalid = 1'b0;
    instr_ack   = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("fault_cleared", 64'(fetch_fault), 64'd0);
`else
    fetch_one(0, 0, 0, 1'b0, 30'd0, $urandom);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
